// File: rtl/retry_ctrl.sv
// Request/retry controller: issues a request, waits for ack/nack under a cycle timeout,
// re-issues up to MAX_RETRY times. Optional exponential backoff via `RETRY_BACKOFF_EN.
module retry_ctrl #(
  parameter int TIMEOUT   = 100,
  parameter int MAX_RETRY = 3,
  localparam int CNT_W    = $clog2(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             req_valid,
  input  logic             req_ready,
  input  logic             ack,
  input  logic             nack,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [1:0]       dbg_state
);

`ifdef RETRY_BACKOFF_EN
  localparam int MAX_LIMIT = TIMEOUT << MAX_RETRY;
`else
  localparam int MAX_LIMIT = TIMEOUT;
`endif
  localparam int TMR_W = $clog2(MAX_LIMIT);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_req_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_fail;
  logic [CNT_W-1:0] r_retry_cnt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_limit_m1;
  logic             w_timeout;
  logic             w_done;
  logic             w_fail;
  logic             w_cnt_clr;
  logic             w_cnt_inc;

`ifdef RETRY_BACKOFF_EN
  logic [31:0] w_limit_full;
  assign w_limit_full = 32'(TIMEOUT) << r_retry_cnt;
  assign w_limit_m1   = TMR_W'(w_limit_full - 32'd1);
`else
  assign w_limit_m1   = TMR_W'(TIMEOUT - 1);
`endif

  assign w_timeout = (r_timer == w_limit_m1);

  // Handshake: req_valid rises on entry to ISSUE and stays high until the cycle in
  // which req_ready is also high; that edge transfers the request and leaves ISSUE.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_fail       = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    if (abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_next_state = ISSUE;
            w_cnt_clr    = 1'b1;
          end
        end
        ISSUE: begin
          if (r_req_valid && req_ready) w_next_state = WAIT;
        end
        WAIT: begin
          if (ack) begin
            w_next_state = IDLE;
            w_done       = 1'b1;
          end else if (nack || w_timeout) begin
            if (r_retry_cnt == MAX_CNT) begin
              w_next_state = IDLE;
              w_fail       = 1'b1;
            end else begin
              w_next_state = ISSUE;
              w_cnt_inc    = 1'b1;
            end
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_retry_cnt <= '0;
      r_timer     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_req_valid <= (w_next_state == ISSUE);
      r_busy      <= (w_next_state != IDLE);
      r_done      <= w_done;
      r_fail      <= w_fail;
      if (w_cnt_clr) r_retry_cnt <= '0;
      else if (w_cnt_inc) r_retry_cnt <= r_retry_cnt + CNT_W'(1);
      // Timer only runs while staying in WAIT and saturates at the current limit.
      if (r_state == WAIT && w_next_state == WAIT) begin
        if (!w_timeout) r_timer <= r_timer + TMR_W'(1);
      end else begin
        r_timer <= '0;
      end
    end
  end

  assign req_valid = r_req_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign retry_cnt = r_retry_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_retry_ctrl.sv
// Directed bench for retry_ctrl with TIMEOUT=4, MAX_RETRY=2. Cycle c is the period after
// rising edge c; inputs are driven and outputs sampled at the falling edge inside cycle c.
module tb_retry_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, req_ready, ack, nack;
  logic       req_valid, busy, done, fail;
  logic [1:0] retry_cnt;
  logic [1:0] dbg_state;
  int checks = 0;
  int errors = 0;

  retry_ctrl #(.TIMEOUT(4), .MAX_RETRY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready), .ack(ack), .nack(nack),
    .busy(busy), .done(done), .fail(fail), .retry_cnt(retry_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Outputs packed as {req_valid, busy, done, fail}.
  function automatic logic [3:0] outs();
    return {req_valid, busy, done, fail};
  endfunction

  task automatic idle_inputs();
    start = 0; abort = 0; ack = 0; nack = 0; req_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 4'b0000) begin
      errors++; $display("FAIL reset_outs got %b want 0000", outs());
    end
    checks++;
    if (retry_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", retry_cnt);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_clean_success();
    logic [3:0] exp_t [0:5] = '{4'b0000, 4'b1100, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (outs() !== exp_t[c]) begin
        errors++; $display("FAIL clean c%0d got %b want %b", c, outs(), exp_t[c]);
      end
      start = (c == 0); ack = (c == 3);
    end
    idle_inputs();
    checks++;
    if (retry_cnt !== 2'd0) begin
      errors++; $display("FAIL clean_cnt got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_t [0:9] = '{4'b0000, 4'b1100, 4'b0100, 4'b0100, 4'b0010,
                                4'b1100, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (outs() !== exp_t[c]) begin
        errors++; $display("FAIL b2b c%0d got %b want %b", c, outs(), exp_t[c]);
      end
      start = (c == 0 || c == 4); ack = (c == 3 || c == 7);
    end
    idle_inputs();
  endtask

  task automatic test_nack_retry();
    logic [3:0] exp_t [0:6] = '{4'b0000, 4'b1100, 4'b0100, 4'b1100, 4'b0100, 4'b0010, 4'b0000};
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if (outs() !== exp_t[c]) begin
        errors++; $display("FAIL nack c%0d got %b want %b", c, outs(), exp_t[c]);
      end
      start = (c == 0); nack = (c == 2); ack = (c == 4);
    end
    idle_inputs();
    checks++;
    if (retry_cnt !== 2'd1) begin
      errors++; $display("FAIL nack_cnt got %0d want 1", retry_cnt);
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_t [0:4] = '{4'b0000, 4'b1100, 4'b0100, 4'b0010, 4'b0000};
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (outs() !== exp_t[c]) begin
        errors++; $display("FAIL prio c%0d got %b want %b", c, outs(), exp_t[c]);
      end
      start = (c == 0); ack = (c == 2); nack = (c == 2);
    end
    idle_inputs();
    checks++;
    if (retry_cnt !== 2'd0) begin
      errors++; $display("FAIL prio_cnt got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_t [0:10] = '{4'b0000, 4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                 4'b1100, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (outs() !== exp_t[c]) begin
        errors++; $display("FAIL timeout c%0d got %b want %b", c, outs(), exp_t[c]);
      end
      start = (c == 0); ack = (c == 8);
    end
    idle_inputs();
    checks++;
    if (retry_cnt !== 2'd1) begin
      errors++; $display("FAIL timeout_cnt got %0d want 1", retry_cnt);
    end
  endtask

  task automatic test_exhaustion();
    logic [3:0] e;
    int n_done = 0;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk);
      e = {(c == 1 || c == 6 || c == 11), (c >= 1 && c <= 15), 1'b0, (c == 16)};
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL exhaust c%0d got %b want %b", c, outs(), e);
      end
      if (done) n_done++;
      start = (c == 0);
    end
    idle_inputs();
    checks++;
    if (retry_cnt !== 2'd2 || n_done != 0) begin
      errors++; $display("FAIL exhaust_end cnt %0d done %0d want cnt 2 done 0", retry_cnt, n_done);
    end
  endtask

  task automatic test_stall();
    logic [3:0] e;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      e = {((c >= 1 && c <= 6) || c == 11), (c >= 1 && c <= 13), (c == 14), 1'b0};
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL stall c%0d got %b want %b", c, outs(), e);
      end
      start = (c == 0); req_ready = !(c >= 1 && c <= 5); ack = (c == 13);
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    logic [3:0] exp_t [0:8] = '{4'b0000, 4'b1100, 4'b0100, 4'b1100, 4'b0100, 4'b0100,
                                4'b0000, 4'b0000, 4'b0000};
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (outs() !== exp_t[c]) begin
        errors++; $display("FAIL abort c%0d got %b want %b", c, outs(), exp_t[c]);
      end
      start = (c == 0); nack = (c == 2); abort = (c == 5); ack = (c == 6);
    end
    idle_inputs();
    checks++;
    if (retry_cnt !== 2'd1) begin
      errors++; $display("FAIL abort_cnt got %0d want 1", retry_cnt);
    end
  endtask

  task automatic test_reset_mid_issue();
    @(negedge clk);
    start = 1; req_ready = 0;
    @(negedge clk);
    start = 0;
    checks++;
    if (outs() !== 4'b1100) begin
      errors++; $display("FAIL rst_pre got %b want 1100", outs());
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (outs() !== 4'b0000 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL rst_mid got %b cnt %0d want 0000 cnt 0", outs(), retry_cnt);
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    @(negedge clk);
  endtask

`ifdef RETRY_BACKOFF_EN
  task automatic test_backoff();
    logic [3:0] e;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      e = {(c == 1 || c == 6 || c == 15), (c >= 1 && c <= 31), 1'b0, (c == 32)};
      checks++;
      if (outs() !== e) begin
        errors++; $display("FAIL backoff c%0d got %b want %b", c, outs(), e);
      end
      start = (c == 0);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_clean_success();
    test_back_to_back();
    test_nack_retry();
    test_priority();
    test_abort();
`ifdef RETRY_BACKOFF_EN
    test_backoff();
`else
    test_timeout();
    test_exhaustion();
    test_stall();
`endif
    test_reset_mid_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/retry_ctrl.md
# retry_ctrl

Request/retry controller for the Retry subsystem. It issues a request over a valid/ready handshake, then waits for an ack or nack under a cycle timeout. On nack or timeout it re-issues, up to a bounded number of retries, and finally reports success or failure. It is the initiating side of the timeout-count interface: it drives its own clear/enable-style timer internally and is the consumer of the timeout flag.

## Interface
Parameters:
- TIMEOUT, 100: number of WAIT cycles without a response before a timeout (≥2).
- MAX_RETRY, 3: maximum number of re-issues after the first attempt (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a transaction; sampled only in IDLE.
- abort  in  1  cancel the current transaction.
- req_valid  out  1  request valid, registered.
- req_ready  in  1  downstream accepts the request.
- ack  in  1  positive response; sampled only in WAIT.
- nack  in  1  negative response; sampled only in WAIT.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle success pulse.
- fail  out  1  one-cycle failure pulse (retries exhausted).
- retry_cnt  out  $clog2(MAX_RETRY+1)  retries performed in the current or last transaction.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - start=1 → ISSUE; retry_cnt cleared to 0.
  - start is ignored in every other state.
- ISSUE:
  - req_valid=1.
  - req_valid && req_ready → WAIT; timer cleared to 0.
  - req_valid stays high until accepted.
- WAIT:
  - Timer increments every cycle.
  - Response priority in the same cycle: ack > nack > timeout.
  - ack → IDLE, done pulse.
  - nack, or timer == limit−1 with no ack/nack: if retry_cnt == MAX_RETRY → IDLE with fail pulse; otherwise retry_cnt+1 and → ISSUE.
- abort (any state) → IDLE next cycle, highest priority.
  - No done/fail pulse; req_valid drops.
  - retry_cnt holds its value.
- ack/nack outside WAIT are ignored.
- retry_cnt holds after completion until the next accepted start.
- Timer saturates at limit−1 and cannot wrap. Timer width is $clog2 of the maximum limit.
- Reset values: state IDLE, req_valid 0, busy 0, done 0, fail 0, retry_cnt 0, timer 0.
- Reset mid-transaction returns the block to IDLE immediately (asynchronous); no pulse is emitted.

## Timing
- start sampled at edge N → req_valid and busy high from N+1.
- Handshake at edge M → WAIT from M+1; req_valid low from M+1.
- Response (ack, or the failing nack/timeout) at edge K → done/fail high during K+1 only; busy low from K+1.
- A start at K+1 is accepted (back-to-back transactions).
- Retrying nack/timeout at edge K → req_valid high from K+1.
- Timeout: with no response, the timeout decision occurs at the limit-th WAIT cycle, i.e. limit cycles after WAIT entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- RETRY_BACKOFF_EN defined: exponential backoff. The limit for attempt k (k = retry_cnt) is TIMEOUT << k. The timer is sized for TIMEOUT << MAX_RETRY.
- RETRY_BACKOFF_EN undefined: the limit is always TIMEOUT; the timer is sized for TIMEOUT.

## Test plan
All scenarios use TIMEOUT=4, MAX_RETRY=2, req_ready=1, backoff off.
- Clean success: start at cycle 0, ack at cycle 3 → req_valid high in cycle 1 only; done=1 in cycle 4; retry_cnt=0; busy low from cycle 4.
- Single timeout then ack: start at 0, no response in WAIT cycles 2–5 → req_valid high again in cycle 6; ack at 8 → done in cycle 9; retry_cnt=1.
- Exhaustion: start at 0 with ack/nack never asserted → three req_valid pulses; fail=1 for one cycle; retry_cnt=2; done never asserted.
- Priority and stall:
  - ack and nack in the same WAIT cycle → done, no retry.
  - With req_ready=0 for 5 cycles, req_valid holds high, the timer does not run, and no timeout occurs.
- Abort and reset:
  - abort during WAIT → IDLE next cycle; no done/fail; ack one cycle later ignored.
  - rst_n low mid-ISSUE → all outputs 0 immediately.
- Backoff (RETRY_BACKOFF_EN): no responses → WAIT lengths of 4, 8 and 16 cycles, then fail.
